// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_pkg
// Description : FSM state encoding, parity-mode constants and the parity-error
//               helper shared by the serial frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_frame_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;
    localparam logic [1:0] c_ST_STOP   = 2'd3;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // i_ones_odd is the XOR of payload and parity bit (1 = odd total of ones)
    function automatic logic f_par_err(input logic i_ones_odd, input int i_mode);
        case (i_mode)
            PARITY_ODD:  return !i_ones_odd;
            PARITY_EVEN: return i_ones_odd;
            default:     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for one asynchronous input bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            o_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_ctrl
// Description : Oversampled serial frame receiver (start, data, parity, stop)
//               with frame-error and inactivity-timeout detection.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_ctrl
    import serial_frame_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int MSB_FIRST   = 0,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              sSCL,
    input  logic              sSDA,
    output logic              START,
    output logic [DATA_W-1:0] DATA,
    output logic              VALID,
    output logic              PAR_ERR,
    output logic              FRAME_ERR,
    output logic              TO_ERR
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic              w_scl;
    logic              w_sda;
    logic              w_fall;
    logic              w_timeout;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_sr_nxt;

    logic              r_scl_prev;
    logic              r_pbit;
    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [TW-1:0]     r_to;
    logic [DATA_W-1:0] r_sr;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_scl (.i_clk(CLK), .i_rst(RST), .i_d(sSCL), .o_q(w_scl));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_sda (.i_clk(CLK), .i_rst(RST), .i_d(sSDA), .o_q(w_sda));

    assign w_fall    = r_scl_prev & ~w_scl;
    // A fall in the expiry cycle restarts the count instead of aborting
    assign w_timeout = (r_state != c_ST_IDLE) && !w_fall && (r_to == TW'(TIMEOUT_CYC - 1));
    assign w_sr_nxt  = (MSB_FIRST != 0) ? ((r_sr << 1) | DATA_W'(w_sda))
                                        : ((r_sr >> 1) | (DATA_W'(w_sda) << (DATA_W - 1)));

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = c_ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                c_ST_IDLE:   if (!w_sda) w_state_nxt = c_ST_DATA;
                c_ST_DATA:   if (r_cnt == CW'(DATA_W - 1))
                                 w_state_nxt = (PARITY_MODE == PARITY_NONE) ? c_ST_STOP : c_ST_PARITY;
                c_ST_PARITY: w_state_nxt = c_ST_STOP;
                default:     w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_scl_prev <= 1'b1;
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_to       <= '0;
            r_sr       <= '0;
            r_pbit     <= 1'b0;
            START      <= 1'b0;
            DATA       <= '0;
            VALID      <= 1'b0;
            PAR_ERR    <= 1'b0;
            FRAME_ERR  <= 1'b0;
            TO_ERR     <= 1'b0;
        end else begin
            r_scl_prev <= w_scl;
            r_state    <= w_state_nxt;
            START      <= (w_state_nxt != c_ST_IDLE);
            VALID      <= 1'b0;
            FRAME_ERR  <= 1'b0;
            TO_ERR     <= w_timeout;

            if (w_fall || w_timeout || (r_state == c_ST_IDLE))
                r_to <= '0;
            else
                r_to <= r_to + TW'(1);

            if (w_fall) begin
                case (r_state)
                    c_ST_IDLE: r_cnt <= '0;
                    c_ST_DATA: begin
                        r_sr  <= w_sr_nxt;
                        r_cnt <= r_cnt + CW'(1);
                    end
                    c_ST_PARITY: r_pbit <= w_sda;
                    c_ST_STOP: begin
                        if (w_sda) begin
                            DATA    <= r_sr;
                            VALID   <= 1'b1;
                            PAR_ERR <= f_par_err(^{r_sr, r_pbit}, PARITY_MODE);
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_ctrl
// Description : Bench for serial_frame_ctrl: two configurations driven from a
//               shared serial bus, checked against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_frame_ctrl;

    localparam int TO_CYC = 64;

    logic CLK  = 1'b0;
    logic RST  = 1'b1;
    logic sSCL = 1'b1;
    logic sSDA = 1'b1;

    logic        o_start [2];
    logic        o_valid [2];
    logic        o_perr  [2];
    logic        o_ferr  [2];
    logic        o_to    [2];
    logic [7:0]  a_data;
    logic [11:0] b_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    serial_frame_ctrl #(.DATA_W(8), .PARITY_MODE(1), .MSB_FIRST(0), .TIMEOUT_CYC(TO_CYC)) dut_a (
        .CLK(CLK), .RST(RST), .sSCL(sSCL), .sSDA(sSDA), .START(o_start[0]), .DATA(a_data),
        .VALID(o_valid[0]), .PAR_ERR(o_perr[0]), .FRAME_ERR(o_ferr[0]), .TO_ERR(o_to[0]));

    serial_frame_ctrl #(.DATA_W(12), .PARITY_MODE(0), .MSB_FIRST(1), .TIMEOUT_CYC(TO_CYC)) dut_b (
        .CLK(CLK), .RST(RST), .sSCL(sSCL), .sSDA(sSDA), .START(o_start[1]), .DATA(b_data),
        .VALID(o_valid[1]), .PAR_ERR(o_perr[1]), .FRAME_ERR(o_ferr[1]), .TO_ERR(o_to[1]));

    function automatic int cfg_dw(input int i);  return (i == 0) ? 8 : 12; endfunction
    function automatic int cfg_par(input int i); return (i == 0) ? 1 : 0;  endfunction
    function automatic int cfg_msb(input int i); return (i == 0) ? 0 : 1;  endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h (t=%0t)", nm, inst, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int          m_pos   [2];   // -1 idle, else number of data/parity bits collected
    int          m_since [2];
    logic        m_bits  [2][17];
    logic [15:0] e_data  [2];
    logic        e_start [2];
    logic        e_valid [2];
    logic        e_perr  [2];
    logic        e_ferr  [2];
    logic        e_to    [2];
    logic        h_scl   [3];
    logic        h_sda   [3];
    logic        mf, mb;

    task automatic model_step(input int i, input logic fall, input logic b);
        int          total;
        int          ones;
        logic [15:0] p;
        total      = cfg_dw(i) + cfg_par(i);
        e_valid[i] = 1'b0;
        e_ferr[i]  = 1'b0;
        e_to[i]    = 1'b0;
        if (fall) begin
            m_since[i] = 0;
            if (m_pos[i] < 0) begin
                if (!b) m_pos[i] = 0;
            end else if (m_pos[i] < total) begin
                m_bits[i][m_pos[i]] = b;
                m_pos[i]++;
            end else begin
                if (b) begin
                    p = '0;
                    for (int j = 0; j < cfg_dw(i); j++)
                        if (m_bits[i][j]) p[(cfg_msb(i) != 0) ? cfg_dw(i) - 1 - j : j] = 1'b1;
                    ones = $countones(p) + ((cfg_par(i) != 0) ? int'(m_bits[i][cfg_dw(i)]) : 0);
                    e_data[i]  = p;
                    e_valid[i] = 1'b1;
                    e_perr[i]  = (cfg_par(i) == 1) ? (ones % 2 != 1) :
                                 (cfg_par(i) == 2) ? (ones % 2 != 0) : 1'b0;
                end else begin
                    e_ferr[i] = 1'b1;
                end
                m_pos[i] = -1;
            end
        end else if (m_pos[i] >= 0) begin
            m_since[i]++;
            if (m_since[i] == TO_CYC) begin
                e_to[i]  = 1'b1;
                m_pos[i] = -1;
            end
        end
        e_start[i] = (m_pos[i] >= 0);
    endtask

    // The receiver acts on what the bus showed two samples ago
    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            for (int k = 0; k < 3; k++) begin h_scl[k] = 1'b1; h_sda[k] = 1'b1; end
            for (int i = 0; i < 2; i++) begin
                m_pos[i] = -1; m_since[i] = 0; e_data[i] = '0; e_start[i] = 1'b0;
                e_valid[i] = 1'b0; e_perr[i] = 1'b0; e_ferr[i] = 1'b0; e_to[i] = 1'b0;
            end
        end else begin
            mf = !h_scl[1] && h_scl[2];
            mb = h_sda[1];
            for (int i = 0; i < 2; i++) model_step(i, mf, mb);
            h_scl[2] = h_scl[1]; h_scl[1] = h_scl[0]; h_scl[0] = sSCL;
            h_sda[2] = h_sda[1]; h_sda[1] = h_sda[0]; h_sda[0] = sSDA;
        end
    end

    // ---------------- compare and event monitor ----------------
    int   valid_cnt [2] = '{0, 0};
    int   ferr_cnt  [2] = '{0, 0};
    int   to_cnt    [2] = '{0, 0};
    int   to_cyc    [2] = '{0, 0};
    int   st_cnt    [2] = '{0, 0};
    logic last_perr [2] = '{1'b0, 1'b0};
    logic [15:0] act_d;

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            act_d = (i == 0) ? 16'(a_data) : 16'(b_data);
            chk("START",     i, 32'(o_start[i]), RST ? 32'd0 : 32'(e_start[i]));
            chk("VALID",     i, 32'(o_valid[i]), RST ? 32'd0 : 32'(e_valid[i]));
            chk("FRAME_ERR", i, 32'(o_ferr[i]),  RST ? 32'd0 : 32'(e_ferr[i]));
            chk("TO_ERR",    i, 32'(o_to[i]),    RST ? 32'd0 : 32'(e_to[i]));
            chk("DATA",      i, 32'(act_d),      RST ? 32'd0 : 32'(e_data[i]));
            if (RST)
                chk("PAR_ERR_rst", i, 32'(o_perr[i]), 32'd0);
            else if (e_valid[i])
                chk("PAR_ERR", i, 32'(o_perr[i]), 32'(e_perr[i]));
            if (o_valid[i]) begin valid_cnt[i]++; last_perr[i] = o_perr[i]; end
            if (o_ferr[i])  ferr_cnt[i]++;
            if (o_to[i])    begin to_cnt[i]++; to_cyc[i] = cyc; end
            if (o_start[i]) st_cnt[i]++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic s, input logic d);
        @(posedge CLK);
        #2;
        sSCL = s;
        sSDA = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, sSDA);
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        repeat (hi) step(1'b1, b);
        repeat (lo) step(1'b0, b);
    endtask

    task automatic send_frame(input logic [15:0] pay, input int dw, input logic msb,
                              input logic has_par, input logic pbit, input logic stopb, input logic rnd);
        int hi, lo;
        hi = 2; lo = 2;
        if (rnd) begin hi = $urandom_range(1, 3); lo = $urandom_range(1, 3); end
        send_bit(1'b0, hi, lo);
        for (int j = 0; j < dw; j++) begin
            if (rnd) begin hi = $urandom_range(1, 3); lo = $urandom_range(1, 3); end
            send_bit(msb ? pay[dw - 1 - j] : pay[j], hi, lo);
        end
        if (has_par) send_bit(pbit, hi, lo);
        send_bit(stopb, hi, lo);
        step(1'b1, 1'b1);
    endtask

    int          v0, f0, t0c, s0, t0, pulses0;
    int          dw, nb;
    logic [15:0] pay;
    logic        msb, hp, sb;

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_DATA",  0, 32'(a_data),     32'h0);
        chk("reset_START", 0, 32'(o_start[0]), 32'h0);
        chk("reset_VALID", 0, 32'(o_valid[0]), 32'h0);
        #1 RST = 1'b0;
        idle(4);

        // good frame A5, odd parity bit 1
        v0 = valid_cnt[0]; s0 = st_cnt[0];
        send_frame(16'h00A5, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(5);
        chk("A5_valid_pulses", 0, 32'(valid_cnt[0] - v0), 32'd1);
        chk("A5_data",         0, 32'(a_data),            32'hA5);
        chk("A5_model_data",   0, 32'(e_data[0]),         32'hA5);
        chk("A5_par_err",      0, 32'(last_perr[0]),      32'd0);
        chk("A5_start_cycles", 0, 32'(st_cnt[0] - s0),    32'd40);

        // same payload, wrong parity bit
        v0 = valid_cnt[0];
        send_frame(16'h00A5, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(5);
        chk("A5bad_valid_pulses", 0, 32'(valid_cnt[0] - v0), 32'd1);
        chk("A5bad_par_err",      0, 32'(last_perr[0]),      32'd1);
        chk("A5bad_data",         0, 32'(a_data),            32'hA5);

        // stop bit 0: frame error, DATA held
        v0 = valid_cnt[0]; f0 = ferr_cnt[0];
        send_frame(16'h003C, 8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        chk("stop0_ferr_pulses",  0, 32'(ferr_cnt[0] - f0),  32'd1);
        chk("stop0_valid_pulses", 0, 32'(valid_cnt[0] - v0), 32'd0);
        chk("stop0_data_held",    0, 32'(a_data),            32'hA5);
        idle(80);

        // timeout: clock stops low after the third data bit
        v0 = valid_cnt[0]; t0c = to_cnt[0];
        send_bit(1'b0, 2, 2);
        send_bit(1'b1, 2, 2);
        send_bit(1'b0, 2, 2);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        t0 = cyc;
        for (int k = 0; k < 120 && to_cnt[0] == t0c; k++) @(posedge CLK);
        #6;
        chk("to_pulses",     0, 32'(to_cnt[0] - t0c),  32'd1);
        chk("to_latency",    0, 32'(to_cyc[0] - t0),   32'd67);
        chk("to_start_low",  0, 32'(o_start[0]),       32'd0);
        chk("to_no_valid",   0, 32'(valid_cnt[0] - v0), 32'd0);
        idle(80);
        v0 = valid_cnt[0];
        send_frame(16'h0096, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(5);
        chk("after_to_valid", 0, 32'(valid_cnt[0] - v0), 32'd1);
        chk("after_to_data",  0, 32'(a_data),            32'h96);
        idle(80);

        // 12-bit MSB-first, no parity
        v0 = valid_cnt[1];
        send_frame(16'h0C3A, 12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        chk("C3A_valid_pulses", 1, 32'(valid_cnt[1] - v0), 32'd1);
        chk("C3A_data",         1, 32'(b_data),            32'hC3A);
        chk("C3A_model_data",   1, 32'(e_data[1]),         32'hC3A);
        chk("C3A_par_err",      1, 32'(last_perr[1]),      32'd0);
        idle(80);

        // reset after five data bits
        send_bit(1'b0, 2, 2);
        for (int j = 0; j < 5; j++) send_bit(j[0], 2, 2);
        step(1'b1, 1'b1);
        pulses0 = valid_cnt[0] + ferr_cnt[0] + to_cnt[0] + valid_cnt[1] + ferr_cnt[1] + to_cnt[1];
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_START", 0, 32'(o_start[0]), 32'd0);
        chk("rst_mid_DATA",  0, 32'(a_data),     32'd0);
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        idle(90);
        chk("rst_no_pulse", 0,
            32'(valid_cnt[0] + ferr_cnt[0] + to_cnt[0] + valid_cnt[1] + ferr_cnt[1] + to_cnt[1] - pulses0), 32'd0);
        v0 = valid_cnt[0];
        send_frame(16'h005A, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(5);
        chk("rst_5A_valid", 0, 32'(valid_cnt[0] - v0), 32'd1);
        chk("rst_5A_data",  0, 32'(a_data),            32'h5A);
        idle(80);

        // randomized traffic, checked every cycle by the compare process
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) begin dw = 8;  msb = 1'b0; hp = 1'b1; end
            else                           begin dw = 12; msb = 1'b1; hp = 1'b0; end
            pay = 16'($urandom);
            sb  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) begin
                nb = $urandom_range(0, dw - 1);
                send_bit(1'b0, $urandom_range(1, 3), $urandom_range(1, 3));
                for (int j = 0; j < nb; j++) send_bit(pay[j], $urandom_range(1, 3), $urandom_range(1, 3));
                idle(70);
            end else begin
                send_frame(pay, dw, msb, hp, 1'($urandom), sb, 1'b1);
            end
            if ($urandom_range(0, 19) == 0) begin
                @(posedge CLK); #2 RST = 1'b1;
                repeat (2) @(posedge CLK); #2 RST = 1'b0;
            end
            idle($urandom_range(0, 5));
        end
        idle(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
